// File: rtl/ft_tx_arbiter.sv
// Round-robin packet arbiter onto the FT232H transmit byte stream.
// Define FT_ARB_HDR_EN to send a {4'hA, chan} header byte before each packet.
// Ports:
//   clk, rst_n              system clock, synchronous active-low reset
//   req_data/avail/last     per-requester byte, valid and end-of-packet flag
//   req_pull                per-requester byte consumed this cycle
//   tx_data/tx_avail        byte stream to the FT232H
//   tx_pull                 FT232H accepts tx_data this cycle
//   grant                   one-hot current owner, 0 when idle
//   stall_err               one-cycle pulse when the stall watchdog aborts a packet
module ft_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int STALL_LIMIT = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_avail,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_pull,
   output logic [7:0]             tx_data,
   output logic                   tx_avail,
   input  logic                   tx_pull,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   stall_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
   localparam bit WD_EN = (STALL_LIMIT > 0);
   localparam logic [CW-1:0] CNT_LAST = WD_EN ? CW'(STALL_LIMIT - 1) : '0;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

`ifdef FT_ARB_HDR_EN
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
   localparam state_t FIRST = HDR;
`else
   typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
   localparam state_t FIRST = PAYLOAD;
`endif

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   last_grant, last_grant_nxt;
   logic [IW-1:0]   pick;
   logic            found;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            stall_nxt;
   logic            cur_avail, cur_last;

   assign cur_avail = req_avail[owner];
   assign cur_last  = req_last[owner];

   // Search upward from last_grant+1 with wrap; the descending loop lets
   // the nearest candidate overwrite the farther ones.
   always_comb begin
      int j;
      logic [IW-1:0] c;
      j     = 0;
      c     = '0;
      pick  = '0;
      found = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = int'(last_grant) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         c = IW'(j);
         if (req_avail[c]) begin
            pick  = c;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      stall_nxt      = 1'b0;
      grant          = '0;
      tx_avail       = 1'b0;
      tx_data        = '0;
      req_pull       = '0;
      if (state != IDLE) grant[owner] = 1'b1;
      unique case (state)
         IDLE: begin
            if (found) begin
               owner_nxt = pick;
               cnt_nxt   = '0;
               state_nxt = FIRST;
            end
         end
`ifdef FT_ARB_HDR_EN
         HDR: begin
            tx_avail = 1'b1;
            tx_data  = {4'hA, 4'(owner)};
            if (tx_pull) begin
               state_nxt = PAYLOAD;
               cnt_nxt   = '0;
            end
         end
`endif
         PAYLOAD: begin
            tx_avail        = cur_avail;
            tx_data         = req_data[8*owner +: 8];
            req_pull[owner] = cur_avail & tx_pull;
            if (cur_avail) begin
               // Backpressure (avail without pull) holds the counter.
               if (tx_pull) begin
                  cnt_nxt = '0;
                  if (cur_last) begin
                     state_nxt      = IDLE;
                     last_grant_nxt = owner;
                  end
               end
            end else if (WD_EN) begin
               if (cnt == CNT_LAST) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = owner;
                  cnt_nxt        = '0;
                  stall_nxt      = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // The in-flight byte must not be consumed while reset is asserted.
      if (!rst_n) begin
         tx_avail = 1'b0;
         req_pull = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         last_grant <= LAST_IDX;
         cnt        <= '0;
         stall_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         cnt        <= cnt_nxt;
         stall_err  <= stall_nxt;
      end
   end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Randomized bench for ft_tx_arbiter against a packet-level reference model.
// Works with or without FT_ARB_HDR_EN defined.
module tb_ft_tx_arbiter;

   localparam int N   = 4;
   localparam int LIM = 8;
`ifdef FT_ARB_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*8-1:0] req_data = '0;
   logic [N-1:0]   req_avail = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_pull;
   logic [7:0]     tx_data;
   logic           tx_avail;
   logic           tx_pull = 1'b0;
   logic [N-1:0]   grant;
   logic           stall_err;

   int n_err = 0;
   int n_chk = 0;

   ft_tx_arbiter #(.NUM_REQ(N), .STALL_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_data(req_data), .req_avail(req_avail), .req_last(req_last),
      .req_pull(req_pull),
      .tx_data(tx_data), .tx_avail(tx_avail), .tx_pull(tx_pull),
      .grant(grant), .stall_err(stall_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // producers
   logic [7:0] qd[N][$];
   bit         ql[N][$];
   int         gap[N];
   int         hold_gap[N];
   logic [N-1:0] pulled = '0;
   int pull_mode = 0;
   int gap_max = 0;
   logic [7:0] txlog[$];
   int n_stall = 0;

   // reference model state: owner -1 = idle
   int m_own = -1;
   bit m_hdr = 1'b0;
   int m_cnt = 0;
   int m_last = N - 1;
   bit m_err = 1'b0;

   always @(negedge clk) begin : model
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_pull;
      logic         e_av;
      logic [7:0]   e_dat;
      int           p;
      e_gnt  = '0;
      e_pull = '0;
      e_av   = 1'b0;
      e_dat  = '0;
      p      = -1;
      if (m_own >= 0) begin
         e_gnt[m_own] = 1'b1;
         if (m_hdr) begin
            e_av  = 1'b1;
            e_dat = 8'hA0 + 8'(m_own);
         end else begin
            e_av  = req_avail[m_own];
            e_dat = req_data[8*m_own +: 8];
            if (req_avail[m_own] && tx_pull) e_pull[m_own] = 1'b1;
         end
      end
      if (!rst_n) begin
         e_av   = 1'b0;
         e_pull = '0;
      end
      chk("grant", 32'(grant), 32'(e_gnt));
      chk("tx_avail", 32'(tx_avail), 32'(e_av));
      if (e_av) chk("tx_data", 32'(tx_data), 32'(e_dat));
      chk("req_pull", 32'(req_pull), 32'(e_pull));
      chk("stall_err", 32'(stall_err), 32'(m_err));
      pulled = req_pull & req_avail;
      if (tx_avail && tx_pull) txlog.push_back(tx_data);
      if (stall_err) n_stall++;
      m_err = 1'b0;
      if (!rst_n) begin
         m_own  = -1;
         m_hdr  = 1'b0;
         m_cnt  = 0;
         m_last = N - 1;
      end else if (m_own < 0) begin
         for (int k = 1; k <= N; k++)
            if (p < 0 && req_avail[(m_last + k) % N]) p = (m_last + k) % N;
         if (p >= 0) begin
            m_own = p;
            m_hdr = HDR;
            m_cnt = 0;
         end
      end else if (m_hdr) begin
         if (tx_pull) m_hdr = 1'b0;
      end else if (req_avail[m_own]) begin
         if (tx_pull) begin
            m_cnt = 0;
            if (req_last[m_own]) begin
               m_last = m_own;
               m_own  = -1;
            end
         end
      end else begin
         m_cnt++;
         if (m_cnt == LIM) begin
            m_err  = 1'b1;
            m_last = m_own;
            m_own  = -1;
            m_cnt  = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (pulled[i]) begin
            void'(qd[i].pop_front());
            void'(ql[i].pop_front());
            if (hold_gap[i] > 0) gap[i] = hold_gap[i];
            else if (gap_max > 0)
               gap[i] = ($urandom_range(0, 9) == 0) ? LIM + 3
                                                    : $urandom_range(0, gap_max);
            else gap[i] = 0;
            hold_gap[i] = 0;
         end else if (!req_avail[i] && gap[i] > 0) begin
            gap[i]--;
         end
         req_avail[i] = (qd[i].size() > 0) && (gap[i] == 0);
         req_data[8*i +: 8] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
         req_last[i] = (qd[i].size() > 0) ? ql[i][0] : 1'b0;
      end
      case (pull_mode)
         0: tx_pull = 1'b1;
         1: tx_pull = ($urandom_range(0, 3) != 0);
         default: tx_pull = 1'b0;
      endcase
   endtask

   task automatic add_pkt(input int i, input int len);
      for (int b = 0; b < len; b++) begin
         qd[i].push_back(8'($urandom));
         ql[i].push_back(b == len - 1);
      end
   endtask

   function automatic bit busy();
      bit any;
      any = (m_own >= 0);
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) any = 1'b1;
      return any;
   endfunction

   task automatic drain(input int max);
      int c;
      c = 0;
      while (busy() && c < max) begin
         cyc();
         c++;
      end
      chk("drain_timeout", 32'(c >= max), 32'd0);
   endtask

   task automatic wait_payload(input int who, input int max);
      int c;
      c = 0;
      while (!(m_own == who && !m_hdr) && c < max) begin
         cyc();
         c++;
      end
      chk("wait_timeout", 32'(c >= max), 32'd0);
   endtask

   task automatic chk_log(input string tag, input logic [7:0] ex[$]);
      chk({tag, "_len"}, 32'(txlog.size()), 32'(ex.size()));
      for (int k = 0; k < ex.size() && k < txlog.size(); k++)
         chk(tag, 32'(txlog[k]), 32'(ex[k]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout @%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] ex[$];
      int s0;
      for (int i = 0; i < N; i++) begin
         gap[i] = 0;
         hold_gap[i] = 0;
      end
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      // two-byte packet from requester 2
      txlog.delete();
      qd[2].push_back(8'h11); ql[2].push_back(1'b0);
      qd[2].push_back(8'h22); ql[2].push_back(1'b1);
      drain(50);
      ex.delete();
      if (HDR) ex.push_back(8'hA2);
      ex.push_back(8'h11);
      ex.push_back(8'h22);
      chk_log("t1_tx", ex);

      // two-byte packet from requester 0
      txlog.delete();
      qd[0].push_back(8'h01); ql[0].push_back(1'b0);
      qd[0].push_back(8'h02); ql[0].push_back(1'b1);
      drain(50);
      ex.delete();
      if (HDR) ex.push_back(8'hA0);
      ex.push_back(8'h01);
      ex.push_back(8'h02);
      chk_log("t6_tx", ex);

      // all requesters with single-byte packets, round-robin from 1
      txlog.delete();
      ex.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) begin
            qd[i].push_back(8'(16 * r + i + 1));
            ql[i].push_back(1'b1);
         end
      for (int r = 0; r < 2; r++)
         for (int i = 1; i <= N; i++) begin
            if (HDR) ex.push_back(8'hA0 + 8'(i % N));
            ex.push_back(8'(16 * r + (i % N) + 1));
         end
      drain(200);
      chk_log("t2_tx", ex);

      // requester 1 stalls mid-packet while requester 2 waits
      s0 = n_stall;
      hold_gap[1] = 20;
      qd[1].push_back(8'h55); ql[1].push_back(1'b0);
      qd[1].push_back(8'h66); ql[1].push_back(1'b1);
      cyc();
      add_pkt(2, 3);
      drain(300);
      chk("t3_stalls", 32'(n_stall - s0), 32'd1);

      // long host backpressure is never a stall
      s0 = n_stall;
      add_pkt(3, 5);
      wait_payload(3, 50);
      pull_mode = 2;
      tx_pull = 1'b0;
      repeat (100) cyc();
      chk("t4_stalls", 32'(n_stall - s0), 32'd0);
      pull_mode = 0;
      drain(100);

      // reset mid-packet of requester 3, requester 0 then wins
      add_pkt(3, 6);
      wait_payload(3, 50);
      add_pkt(0, 2);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      drain(300);

      // randomized traffic
      pull_mode = 1;
      gap_max = 3;
      for (int it = 0; it < 40; it++) begin
         for (int a = $urandom_range(1, 3); a > 0; a--)
            add_pkt($urandom_range(0, N - 1), $urandom_range(1, 6));
         repeat ($urandom_range(20, 60)) begin
            cyc();
            if ($urandom_range(0, 299) == 0) begin
               rst_n = 1'b0;
               cyc();
               rst_n = 1'b1;
            end
         end
      end
      pull_mode = 0;
      drain(3000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ft_tx_arbiter.md
Name: ft_tx_arbiter

Overview:
Round-robin packet arbiter that shares the single transmit byte stream of the FT232H serial block among NUM_REQ requesters in the system clock domain. A grant is held for a whole packet, delimited by a per-requester last flag. An optional channel header byte precedes each packet. A stall watchdog reclaims the grant from a requester that stops supplying bytes mid-packet. Output connects directly to the FT232H tx_data/tx_avail/tx_pull interface.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
STALL_LIMIT, 1024, consecutive mid-packet cycles without req_avail before abort; 0 disables the watchdog.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  synchronous reset, active-low.
req_data  input  NUM_REQ*8  byte from requester i on bits [8i+7:8i].
req_avail  input  NUM_REQ  requester i has a valid byte.
req_last  input  NUM_REQ  byte from requester i is the final byte of its packet; qualified by req_avail.
req_pull  output  NUM_REQ  byte from requester i consumed this cycle.
tx_data  output  8  byte to FT232H transmit path.
tx_avail  output  1  tx_data valid.
tx_pull  input  1  FT232H accepts tx_data this cycle.
grant  output  NUM_REQ  one-hot current owner; 0 when idle.
stall_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Handshake: a transfer occurs on any cycle where avail and pull are both high. There is no other qualifier. Producers hold data/avail until pulled.
- Reset (rst_n low at clk edge): state=IDLE, grant=0, tx_avail=0, req_pull=0, stall_err=0, stall counter=0, last_grant=NUM_REQ-1 so requester 0 has first priority. Reset mid-packet drops the packet silently with no stall_err. The requester's in-flight byte is not pulled.
- States: IDLE, HDR, PAYLOAD.
- IDLE:
  - tx_avail=0.
  - If any req_avail is set, choose the first set bit searching upward from last_grant+1, with wrap-around.
  - grant is registered on the next edge, together with the state change to HDR (or PAYLOAD when the header feature is compiled out).
  - Arbitration costs exactly 1 idle cycle.
- HDR:
  - tx_avail=1, tx_data={4'hA, chan[3:0]}, where chan is the granted index.
  - On tx_pull, go to PAYLOAD.
  - The watchdog does not count in HDR.
- PAYLOAD:
  - Combinational passthrough: tx_avail=req_avail[g], tx_data=req_data[g], req_pull[g]=req_avail[g]&tx_pull. All other req_pull bits are 0.
  - Zero-cycle latency from request to tx.
  - On a transfer with req_last[g]=1: on the next edge go to IDLE, last_grant=g, grant=0.
- Watchdog:
  - Counter clears on every PAYLOAD transfer and on entry to PAYLOAD.
  - Increments on each PAYLOAD cycle with req_avail[g]=0.
  - If the counter would reach STALL_LIMIT: go to IDLE, set last_grant=g, and pulse stall_err for 1 cycle.
  - A cycle with req_avail[g]=1 but tx_pull=0 does not count; host backpressure is never a stall.
  - Counter width is clog2(STALL_LIMIT+1); it must not wrap.
- Simultaneous events:
  - A last-byte transfer always ends the packet normally; the watchdog cannot fire on a cycle with req_avail[g]=1.
  - Requesters changing req_avail while not granted have no effect.
- grant is never more than one-hot. req_pull is never set for a non-granted requester.

Optional Feature:
Macro FT_ARB_HDR_EN.
- Defined: the HDR state and header byte {4'hA, chan} precede every packet. Minimum packet cost is 1 idle cycle + 1 header byte + payload.
- Undefined: the HDR state is removed and IDLE goes straight to PAYLOAD. The output is raw payload, with packets still never interleaved.

Test Plan:
1. Header on; req 2 sends bytes 0x11,0x22(last), tx_pull held 1. Response: tx sequence 0xA2,0x11,0x22; grant=4'b0100 for 3 cycles after 1 idle cycle; req_pull[2] pulses twice.
2. All 4 requesters continuously sending 1-byte packets (last=1) after reset. Response: grant order 0,1,2,3,0; each tx pair is 0xA<n>,payload.
3. Req 1 mid-packet sends 0x55 then drops avail; STALL_LIMIT=8. Response: exactly 8 stalled cycles, then stall_err=1 for one cycle, grant=0; req 2 (waiting) is granted next.
4. tx_pull held 0 for 100 cycles mid-packet with req_avail=1, STALL_LIMIT=8. Response: no stall_err, data held stable, then resumes on tx_pull=1.
5. rst_n low for one cycle during PAYLOAD of req 3. Response: grant=0, tx_avail=0 on the next cycle; the following grant goes to req 0 if it is requesting.
6. Build without FT_ARB_HDR_EN; req 0 sends 0x01,0x02(last). Response: tx sequence is exactly 0x01,0x02 with no header byte.
